mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single RAM port (mem_clk, mem_size, addr, data_i, data_o) between the CPU (port A) and a secondary master such as a program loader or debug unit (port B).
- Sequences each access through setup, strobe and acknowledge phases.
- Rejects misaligned and invalid-size accesses before they reach the RAM.
- Sits between the CPU/loader and the RAM instance at the top level.

Parameters:
- RR_EN, 1, 1 = round-robin between A and B on contention; 0 = fixed priority, A wins.
- WAIT_CYCLES, 1, extra cycles (0..7) held in SETUP before a read is captured or a write strobe fires.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset asserted.
- a_req  input  1  port A access request; held until a_ack.
- a_we  input  1  port A write enable (1 = write, 0 = read).
- a_size  input  2  port A access size: 00 = byte, 01 = half, 10 = word, 11 = invalid.
- a_addr  input  32  port A byte address.
- a_wdata  input  32  port A write data.
- a_ack  output  1  one-cycle completion pulse for port A.
- a_err  output  1  asserted together with a_ack when the access was rejected.
- a_rdata  output  32  port A read data; valid when a_ack=1.
- b_req, b_we, b_size, b_addr, b_wdata, b_ack, b_err, b_rdata: same as port A, for port B.
- mem_clk  output  1  RAM write strobe.
- mem_size  output  2  size to RAM.
- addr  output  32  address to RAM.
- data_i  output  32  write data to RAM.
- data_o  input  32  read data from RAM (combinational).

Behaviour:
- Reset (reset=0, async):
  - mem_clk, mem_size, addr, data_i, all ack/err and rdata = 0; FSM to IDLE.
  - last_grant = B, so A wins the first contention.
  - mem_clk must drop combinationally on reset assertion; an in-flight access is aborted with no ack.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - No req: stay.
  - Only one req: grant it.
  - Both req: RR_EN=1 grants the requester that is not last_grant; RR_EN=0 grants A.
  - On grant: latch we/size/addr/wdata of the winner, update last_grant, go to SETUP.
- SETUP:
  - Drive mem_size/addr/data_i from the latched values; mem_clk=0.
  - Stay 1+WAIT_CYCLES cycles (down-counter).
  - Then: write → STROBE; read → capture data_o into the winner's rdata and go to DONE.
- STROBE: mem_clk=1 for exactly one cycle, addr/data/size held stable → DONE.
- DONE:
  - Winner's ack=1 for one cycle; addr/size/data_i stay held; → IDLE.
  - The loser's request remains pending and is arbitrated in the following IDLE cycle.
- Latency from req sampled in IDLE to ack (WAIT_CYCLES=W): read 2+W cycles; write 3+W cycles.
- Alignment check at grant:
  - Invalid if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]≠00.
  - Invalid access skips SETUP/STROBE: IDLE → DONE, with ack=1 and err=1, no mem_clk pulse, rdata unchanged.
- Back-to-back: a requester holding req after its ack is treated as a new request. With RR_EN=1 and both requesting, grants alternate A, B, A, B.
- Requester inputs may change freely after grant because they are latched. A req dropped before ack does not cancel the access.
- rdata holds its value until the next successful read for that port.
- At most one of a_ack/b_ack is high in any cycle; mem_clk is never high outside STROBE.

Test Plan:
- Reset: hold reset=0 with a_req=1 → mem_clk=0, acks=0, addr=0. Release → A granted; ack at cycle 3 for a read with WAIT_CYCLES=1.
- Port A word write: addr=0x100, wdata=0xDEADBEEF, size=10, then word read of 0x100 → exactly one mem_clk pulse with addr=0x100, data_i=0xDEADBEEF; a_rdata=0xDEADBEEF on a_ack; a_err=0.
- Contention with RR_EN=1: a_req and b_req held high for 4 transactions → ack order A, B, A, B; no overlapping acks.
- Contention with RR_EN=0: same stimulus → all grants to A while a_req is high; B is served only once a_req drops.
- Misaligned access: b_size=10, b_addr=0x102, write → b_ack=1 and b_err=1 one cycle after the grant; no mem_clk pulse; memory word at 0x100 unchanged.
- Reset mid-write: drive reset=0 during STROBE → mem_clk falls immediately; no ack. After release, the same request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one RAM port between two masters: the CPU on port A and a
//   secondary master such as a loader or debug unit on port B. Every
//   accepted access passes through four phases: arbitration (IDLE), address
//   setup (SETUP), write strobe (STROBE, writes only) and a one-cycle
//   acknowledge (DONE). Accesses with an invalid size or a misaligned
//   address are rejected at grant time and never reach the RAM.
//
// Parameters:
//   RR_EN        1 = alternate between A and B on contention,
//                0 = fixed priority, A always wins.
//   WAIT_CYCLES  Extra SETUP cycles (0..7) before a read is captured or a
//                write strobe fires.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous reset, active low (0 = in reset)
//   a_req / b_req       access request, held by the master until its ack
//   a_we / b_we         1 = write, 0 = read
//   a_size / b_size     00 byte, 01 half, 10 word, 11 invalid
//   a_addr / b_addr     byte address
//   a_wdata / b_wdata   write data
//   a_ack / b_ack       one-cycle completion pulse
//   a_err / b_err       high together with ack when the access was rejected
//   a_rdata / b_rdata   last successfully read data for that port
//   mem_clk             RAM write strobe
//   mem_size            access size to the RAM
//   addr                address to the RAM
//   data_i              write data to the RAM
//   data_o              read data from the RAM (combinational)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter logic        RR_EN       = 1'b1,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        mem_clk,
    output logic [1:0]  mem_size,
    output logic [31:0] addr,
    output logic [31:0] data_i,
    input  logic [31:0] data_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_t;

    localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

    state_t      r_state;
    state_t      w_nextState;

    logic        r_lastGrantB;
    logic        r_ownerB;
    logic        r_we;
    logic        r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_waitCnt;
    logic [31:0] r_aRdata;
    logic [31:0] r_bRdata;

    logic        w_pickB;
    logic        w_selWe;
    logic [1:0]  w_selSize;
    logic [31:0] w_selAddr;
    logic [31:0] w_selWdata;
    logic        w_selBad;
    logic        w_setupDone;
    logic        w_grant;
    logic        w_capture;

    // An access is rejected when the size code is invalid or the address is
    // not naturally aligned to the access size.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b00:   isMisaligned = 1'b0;
            2'b01:   isMisaligned = lsb[0];
            2'b10:   isMisaligned = (lsb != 2'b00);
            default: isMisaligned = 1'b1;
        endcase
    endfunction

    // Winner selection. On contention round-robin hands the grant to whoever
    // did not win last time; a lone requester always wins.
    always_comb begin
        if (a_req && b_req) begin
            w_pickB = RR_EN ? ~r_lastGrantB : 1'b0;
        end else begin
            w_pickB = b_req;
        end
    end

    assign w_selWe     = w_pickB ? b_we    : a_we;
    assign w_selSize   = w_pickB ? b_size  : a_size;
    assign w_selAddr   = w_pickB ? b_addr  : a_addr;
    assign w_selWdata  = w_pickB ? b_wdata : a_wdata;
    assign w_selBad    = isMisaligned(w_selSize, w_selAddr[1:0]);
    assign w_setupDone = (r_waitCnt == 3'd0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and per-state outputs. mem_clk is gated with reset
    // so the strobe drops the instant reset is asserted, independent of the
    // state register's reset path.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        mem_clk     = 1'b0;
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        a_err       = 1'b0;
        b_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    w_grant     = 1'b1;
                    w_nextState = w_selBad ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_setupDone) begin
                    if (r_we) begin
                        w_nextState = ST_STROBE;
                    end else begin
                        w_capture   = 1'b1;
                        w_nextState = ST_DONE;
                    end
                end
            end
            ST_STROBE: begin
                mem_clk     = reset;
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                a_ack       = ~r_ownerB;
                b_ack       = r_ownerB;
                a_err       = ~r_ownerB & r_err;
                b_err       = r_ownerB & r_err;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Request latch, setup down-counter and per-port read-data registers.
    // The winner's request is copied at grant so the master may change its
    // inputs freely afterwards. last_grant resets to B so A wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastGrantB <= 1'b1;
            r_ownerB     <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_waitCnt    <= 3'd0;
            r_aRdata     <= 32'd0;
            r_bRdata     <= 32'd0;
        end else begin
            if (w_grant) begin
                r_lastGrantB <= w_pickB;
                r_ownerB     <= w_pickB;
                r_we         <= w_selWe;
                r_err        <= w_selBad;
                r_size       <= w_selSize;
                r_addr       <= w_selAddr;
                r_wdata      <= w_selWdata;
                r_waitCnt    <= LP_WAIT;
            end else if ((r_state == ST_SETUP) && !w_setupDone) begin
                r_waitCnt <= r_waitCnt - 3'd1;
            end
            if (w_capture) begin
                if (r_ownerB) begin
                    r_bRdata <= data_o;
                end else begin
                    r_aRdata <= data_o;
                end
            end
        end
    end

    assign mem_size = r_size;
    assign addr     = r_addr;
    assign data_i   = r_wdata;
    assign a_rdata  = r_aRdata;
    assign b_rdata  = r_bRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances: dut0 with fixed priority and no wait cycles, dut1
// with round-robin and one wait cycle. Each has a small byte-lane RAM model.
// Stimulus pushes the expected acknowledges and write strobes into queues;
// separate monitor processes pop and compare whenever an ack or a strobe
// appears.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic        err;
        logic        chkRd;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } stb_t;

    logic        clk;
    logic        rst_n;

    logic        reqS   [2][2];
    logic        weS    [2][2];
    logic [1:0]  sizeS  [2][2];
    logic [31:0] addrS  [2][2];
    logic [31:0] wdataS [2][2];
    logic        ackS   [2][2];
    logic        errS   [2][2];
    logic [31:0] rdataS [2][2];

    logic        memClkS   [2];
    logic [1:0]  memSizeS  [2];
    logic [31:0] memAddrS  [2];
    logic [31:0] memDataIS [2];
    logic [31:0] memDataOS [2];

    logic [31:0] ram0 [256];
    logic [31:0] ram1 [256];

    exp_t expQ0[$];
    exp_t expQ1[$];
    stb_t stbQ0[$];
    stb_t stbQ1[$];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.RR_EN(1'b0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .a_req(reqS[0][0]), .a_we(weS[0][0]), .a_size(sizeS[0][0]),
        .a_addr(addrS[0][0]), .a_wdata(wdataS[0][0]),
        .a_ack(ackS[0][0]), .a_err(errS[0][0]), .a_rdata(rdataS[0][0]),
        .b_req(reqS[0][1]), .b_we(weS[0][1]), .b_size(sizeS[0][1]),
        .b_addr(addrS[0][1]), .b_wdata(wdataS[0][1]),
        .b_ack(ackS[0][1]), .b_err(errS[0][1]), .b_rdata(rdataS[0][1]),
        .mem_clk(memClkS[0]), .mem_size(memSizeS[0]), .addr(memAddrS[0]),
        .data_i(memDataIS[0]), .data_o(memDataOS[0])
    );

    mem_arbiter #(.RR_EN(1'b1), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst_n),
        .a_req(reqS[1][0]), .a_we(weS[1][0]), .a_size(sizeS[1][0]),
        .a_addr(addrS[1][0]), .a_wdata(wdataS[1][0]),
        .a_ack(ackS[1][0]), .a_err(errS[1][0]), .a_rdata(rdataS[1][0]),
        .b_req(reqS[1][1]), .b_we(weS[1][1]), .b_size(sizeS[1][1]),
        .b_addr(addrS[1][1]), .b_wdata(wdataS[1][1]),
        .b_ack(ackS[1][1]), .b_err(errS[1][1]), .b_rdata(rdataS[1][1]),
        .mem_clk(memClkS[1]), .mem_size(memSizeS[1]), .addr(memAddrS[1]),
        .data_i(memDataIS[1]), .data_o(memDataOS[1])
    );

    assign memDataOS[0] = ram0[memAddrS[0][9:2]];
    assign memDataOS[1] = ram1[memAddrS[1][9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one request onto a port of a DUT and raises req.
    task automatic applyStimulus(input int d, input int p, input logic we, input logic [1:0] size,
                                 input logic [31:0] a, input logic [31:0] wd);
        weS[d][p]    = we;
        sizeS[d][p]  = size;
        addrS[d][p]  = a;
        wdataS[d][p] = wd;
        reqS[d][p]   = 1'b1;
    endtask

    // Waits (bounded) for the port's ack; lat counts rising edges from the
    // sampling edge up to and including the edge that raises ack.
    task automatic waitAck(input int d, input int p, input bit dropReq, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ackS[d][p]) seen = 1'b1;
        end
        if (!seen) checkOutput($sformatf("d%0d port%0d ackTimeout", d, p), 32'd0, 32'd1);
        if (dropReq) begin
            reqS[d][p] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pushExp(input int d, input int port, input logic err, input logic chkRd, input logic [31:0] rd);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.chkRd = chkRd;
        e.rdata = rd;
        if (d == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    task automatic pushStb(input int d, input logic [31:0] a, input logic [31:0] wd);
        stb_t s;
        s.addr = a;
        s.data = wd;
        if (d == 0) stbQ0.push_back(s);
        else        stbQ1.push_back(s);
    endtask

    function automatic logic [31:0] mergeWrite(input logic [31:0] old, input logic [1:0] size,
                                               input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        int sh;
        r  = old;
        sh = 8 * int'(a[1:0]);
        case (size)
            2'b00:   r[sh +: 8] = wd[7:0];
            2'b01:   if (a[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Ack monitor: pops the expected response for the DUT and compares.
    task automatic monitorDut(input int d);
        exp_t e;
        int   port;
        logic a;
        logic b;
        bit   empty;
        a = ackS[d][0];
        b = ackS[d][1];
        if (a || b) begin
            checkOutput($sformatf("d%0d ackOverlap", d), {31'd0, a & b}, 32'd0);
            empty = (d == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0);
            if (empty) begin
                checkOutput($sformatf("d%0d unexpectedAck", d), 32'd1, 32'd0);
            end else begin
                if (d == 0) e = expQ0.pop_front();
                else        e = expQ1.pop_front();
                port = b ? 1 : 0;
                checkOutput($sformatf("d%0d ackPort", d), port, e.port);
                checkOutput($sformatf("d%0d ackErr", d), {31'd0, errS[d][port]}, {31'd0, e.err});
                if (e.chkRd) checkOutput($sformatf("d%0d ackRdata", d), rdataS[d][port], e.rdata);
            end
        end
    endtask

    always @(negedge clk) begin
        monitorDut(0);
        monitorDut(1);
    end

    // Strobe monitors: check the expected write and update the RAM models.
    always @(posedge memClkS[0]) begin
        stb_t s;
        if (stbQ0.size() == 0) begin
            checkOutput("d0 unexpectedStrobe", 32'd1, 32'd0);
        end else begin
            s = stbQ0.pop_front();
            checkOutput("d0 strobeAddr", memAddrS[0], s.addr);
            checkOutput("d0 strobeData", memDataIS[0], s.data);
        end
        ram0[memAddrS[0][9:2]] = mergeWrite(ram0[memAddrS[0][9:2]], memSizeS[0], memAddrS[0], memDataIS[0]);
    end

    always @(posedge memClkS[1]) begin
        stb_t s;
        if (stbQ1.size() == 0) begin
            checkOutput("d1 unexpectedStrobe", 32'd1, 32'd0);
        end else begin
            s = stbQ1.pop_front();
            checkOutput("d1 strobeAddr", memAddrS[1], s.addr);
            checkOutput("d1 strobeData", memDataIS[1], s.data);
        end
        ram1[memAddrS[1][9:2]] = mergeWrite(ram1[memAddrS[1][9:2]], memSizeS[1], memAddrS[1], memDataIS[1]);
    end

    initial begin
        int lat;
        bit hit;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                reqS[d][p]   = 1'b0;
                weS[d][p]    = 1'b0;
                sizeS[d][p]  = 2'b00;
                addrS[d][p]  = 32'd0;
                wdataS[d][p] = 32'd0;
            end
        end
        for (int i = 0; i < 256; i++) begin
            ram0[i] = 32'd0;
            ram1[i] = 32'd0;
        end
        ram1[64] = 32'h1122_3344;
        ram0[64] = 32'h0101_0101;
        ram0[65] = 32'h0202_0202;
        ram0[66] = 32'h0303_0303;
        ram0[67] = 32'h0B0B_0B0B;

        $display("[TB] reset with a pending request");
        pushExp(1, 0, 1'b0, 1'b1, 32'h1122_3344);
        applyStimulus(1, 0, 1'b0, 2'b10, 32'h100, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("rst memClk", {31'd0, memClkS[1]}, 32'd0);
        checkOutput("rst aAck", {31'd0, ackS[1][0]}, 32'd0);
        checkOutput("rst bAck", {31'd0, ackS[1][1]}, 32'd0);
        checkOutput("rst addr", memAddrS[1], 32'd0);
        checkOutput("rst aRdata", rdataS[1][0], 32'd0);
        rst_n = 1'b1;
        waitAck(1, 0, 1'b1, lat);
        checkOutput("d1 firstReadLatency", lat, 32'd3);

        $display("[TB] port A word write then read");
        pushExp(1, 0, 1'b0, 1'b0, 32'd0);
        pushStb(1, 32'h100, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF);
        waitAck(1, 0, 1'b1, lat);
        checkOutput("d1 writeLatency", lat, 32'd4);
        pushExp(1, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 1'b0, 2'b10, 32'h100, 32'd0);
        waitAck(1, 0, 1'b1, lat);
        checkOutput("d1 readLatency", lat, 32'd3);
        repeat (2) @(negedge clk);
        checkOutput("d1 aRdataHeld", rdataS[1][0], 32'hDEAD_BEEF);

        $display("[TB] half write on A, word read on B");
        pushExp(1, 0, 1'b0, 1'b0, 32'd0);
        pushStb(1, 32'h106, 32'h0000_CAFE);
        applyStimulus(1, 0, 1'b1, 2'b01, 32'h106, 32'h0000_CAFE);
        waitAck(1, 0, 1'b1, lat);
        pushExp(1, 1, 1'b0, 1'b1, 32'hCAFE_0000);
        applyStimulus(1, 1, 1'b0, 2'b10, 32'h104, 32'd0);
        waitAck(1, 1, 1'b1, lat);

        $display("[TB] rejected accesses");
        pushExp(1, 0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 1'b0, 2'b11, 32'h100, 32'd0);
        waitAck(1, 0, 1'b1, lat);
        checkOutput("d1 invalidSizeLatency", lat, 32'd1);
        pushExp(1, 0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1, 0, 1'b1, 2'b01, 32'h101, 32'h1234_5678);
        waitAck(1, 0, 1'b1, lat);
        pushExp(1, 1, 1'b1, 1'b1, 32'hCAFE_0000);
        applyStimulus(1, 1, 1'b1, 2'b10, 32'h102, 32'h5555_5555);
        waitAck(1, 1, 1'b1, lat);
        checkOutput("d1 misalignedLatency", lat, 32'd1);
        checkOutput("d1 ram100Unchanged", ram1[64], 32'hDEAD_BEEF);

        $display("[TB] round-robin contention");
        pushExp(1, 0, 1'b0, 1'b0, 32'd0);
        pushExp(1, 1, 1'b0, 1'b0, 32'd0);
        pushExp(1, 0, 1'b0, 1'b1, 32'hAAAA_0001);
        pushExp(1, 1, 1'b0, 1'b1, 32'hBBBB_0002);
        pushStb(1, 32'h108, 32'hAAAA_0001);
        pushStb(1, 32'h10C, 32'hBBBB_0002);
        fork
            begin
                int latA;
                applyStimulus(1, 0, 1'b1, 2'b10, 32'h108, 32'hAAAA_0001);
                waitAck(1, 0, 1'b0, latA);
                applyStimulus(1, 0, 1'b0, 2'b10, 32'h108, 32'd0);
                waitAck(1, 0, 1'b1, latA);
            end
            begin
                int latB;
                applyStimulus(1, 1, 1'b1, 2'b10, 32'h10C, 32'hBBBB_0002);
                waitAck(1, 1, 1'b0, latB);
                applyStimulus(1, 1, 1'b0, 2'b10, 32'h10C, 32'd0);
                waitAck(1, 1, 1'b1, latB);
            end
        join

        $display("[TB] fixed-priority instance");
        pushExp(0, 0, 1'b0, 1'b0, 32'd0);
        pushStb(0, 32'h110, 32'h1234_5678);
        applyStimulus(0, 0, 1'b1, 2'b10, 32'h110, 32'h1234_5678);
        waitAck(0, 0, 1'b1, lat);
        checkOutput("d0 writeLatency", lat, 32'd3);
        checkOutput("d0 ram110", ram0[68], 32'h1234_5678);
        pushExp(0, 0, 1'b0, 1'b1, 32'h0101_0101);
        pushExp(0, 0, 1'b0, 1'b1, 32'h0202_0202);
        pushExp(0, 0, 1'b0, 1'b1, 32'h0303_0303);
        pushExp(0, 1, 1'b0, 1'b1, 32'h0B0B_0B0B);
        fork
            begin
                int latA;
                applyStimulus(0, 0, 1'b0, 2'b10, 32'h100, 32'd0);
                waitAck(0, 0, 1'b0, latA);
                checkOutput("d0 readLatency", latA, 32'd2);
                applyStimulus(0, 0, 1'b0, 2'b10, 32'h104, 32'd0);
                waitAck(0, 0, 1'b0, latA);
                applyStimulus(0, 0, 1'b0, 2'b10, 32'h108, 32'd0);
                waitAck(0, 0, 1'b1, latA);
            end
            begin
                int latB;
                applyStimulus(0, 1, 1'b0, 2'b10, 32'h10C, 32'd0);
                waitAck(0, 1, 1'b1, latB);
            end
        join

        $display("[TB] reset during write strobe");
        pushExp(1, 0, 1'b0, 1'b0, 32'd0);
        pushStb(1, 32'h110, 32'h0F0F_0F0F);
        pushStb(1, 32'h110, 32'h0F0F_0F0F);
        fork
            begin
                int latA;
                applyStimulus(1, 0, 1'b1, 2'b10, 32'h110, 32'h0F0F_0F0F);
                waitAck(1, 0, 1'b1, latA);
            end
            begin
                hit = 1'b0;
                for (int i = 0; i < 20 && !hit; i++) begin
                    @(posedge clk);
                    #1;
                    if (memClkS[1]) hit = 1'b1;
                end
                checkOutput("d1 strobeReached", {31'd0, hit}, 32'd1);
                rst_n = 1'b0;
                #1;
                checkOutput("d1 memClkDropOnReset", {31'd0, memClkS[1]}, 32'd0);
                checkOutput("d1 noAckOnReset", {31'd0, ackS[1][0]}, 32'd0);
                repeat (2) @(negedge clk);
                checkOutput("d1 addrInReset", memAddrS[1], 32'd0);
                rst_n = 1'b1;
            end
        join
        checkOutput("d1 ram110", ram1[68], 32'h0F0F_0F0F);

        repeat (3) @(negedge clk);
        checkOutput("d0 ackQueueEmpty", expQ0.size(), 32'd0);
        checkOutput("d1 ackQueueEmpty", expQ1.size(), 32'd0);
        checkOutput("d0 strobeQueueEmpty", stbQ0.size(), 32'd0);
        checkOutput("d1 strobeQueueEmpty", stbQ1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
